// File: rtl/board_tile_store.sv
// ============================================================================
// Module   : board_tile_store
// Purpose  : Maze tile memory with display read port, handshaked game writes,
//            start-of-game maze load sweep and edible-tile tracking.
// Revision : 1.0
// ============================================================================
`default_nettype none

module board_tile_store #(
    parameter int COLS = 40,
    parameter int ROWS = 30
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [5:0]  rd_x_i,
    input  logic [5:0]  rd_y_i,
    output logic [2:0]  rd_data_o,
    input  logic        wr_req_i,
    input  logic [5:0]  wr_x_i,
    input  logic [5:0]  wr_y_i,
    input  logic [2:0]  wr_data_i,
    output logic        wr_ack_o,
    input  logic        start_init_i,
    output logic        init_busy_o,
    output logic [10:0] dots_left_o,
    output logic        cleared_o
);

    localparam int          CELLS      = COLS * ROWS;
    localparam logic [10:0] LAST_ADDR  = 11'(CELLS - 1);
    localparam logic [5:0]  COLS_W     = 6'(COLS);
    localparam logic [5:0]  ROWS_W     = 6'(ROWS);
    localparam logic [5:0]  LAST_COL   = 6'(COLS - 1);
    localparam logic [5:0]  LAST_ROW   = 6'(ROWS - 1);
    localparam logic [5:0]  PELLET_COL = 6'(COLS - 2);
    localparam logic [5:0]  PELLET_ROW = 6'(ROWS - 2);
    localparam logic [2:0]  TILE_WALL  = 3'd1;
    localparam logic [2:0]  TILE_DOT   = 3'd2;
    localparam logic [2:0]  TILE_PELL  = 3'd3;

    typedef enum logic [1:0] {
        S_INIT      = 2'd0,
        S_IDLE      = 2'd1,
        S_WR_READ   = 2'd2,
        S_WR_COMMIT = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [10:0] sweep_addr_q, sweep_addr_d;
    logic [5:0]  sweep_x_q, sweep_x_d;
    logic [5:0]  sweep_y_q, sweep_y_d;
    logic [10:0] dots_q, dots_d;
    logic [5:0]  wx_q, wx_d;
    logic [5:0]  wy_q, wy_d;
    logic [2:0]  wdata_q, wdata_d;
    logic        wr_ack_q, wr_ack_d;
    logic [2:0]  old_q;
    logic [2:0]  rd_data_q;

    logic [2:0]  mem_q [CELLS];

    logic [2:0]  w_sweep_code;
    logic        w_wr_in_range;
    logic [10:0] w_wr_addr;
    logic        w_rd_in_range;
    logic [10:0] w_rd_addr;
    logic        w_mem_we;
    logic [10:0] w_mem_addr;
    logic [2:0]  w_mem_din;

    function automatic logic is_edible(input logic [2:0] code);
        return (code == TILE_DOT) || (code == TILE_PELL);
    endfunction

    assign w_wr_in_range = (wx_q < COLS_W) && (wy_q < ROWS_W);
    assign w_wr_addr     = 11'(wy_q) * 11'(COLS) + 11'(wx_q);
    assign w_rd_in_range = (rd_x_i < COLS_W) && (rd_y_i < ROWS_W);
    assign w_rd_addr     = 11'(rd_y_i) * 11'(COLS) + 11'(rd_x_i);

    always_comb begin
        w_sweep_code = TILE_DOT;
        if (sweep_x_q == 6'd0 || sweep_x_q == LAST_COL ||
            sweep_y_q == 6'd0 || sweep_y_q == LAST_ROW) begin
            w_sweep_code = TILE_WALL;
        end else if (sweep_x_q[1:0] == 2'd2 && sweep_y_q[1:0] == 2'd2) begin
            w_sweep_code = TILE_WALL;
        end else if ((sweep_x_q == 6'd1 || sweep_x_q == PELLET_COL) &&
                     (sweep_y_q == 6'd1 || sweep_y_q == PELLET_ROW)) begin
            w_sweep_code = TILE_PELL;
        end
    end

    always_comb begin
        state_d      = state_q;
        sweep_addr_d = sweep_addr_q;
        sweep_x_d    = sweep_x_q;
        sweep_y_d    = sweep_y_q;
        dots_d       = dots_q;
        wx_d         = wx_q;
        wy_d         = wy_q;
        wdata_d      = wdata_q;
        wr_ack_d     = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_addr   = sweep_addr_q;
        w_mem_din    = w_sweep_code;
        case (state_q)
            S_INIT: begin
                w_mem_we = 1'b1;
                if (is_edible(w_sweep_code)) dots_d = dots_q + 11'd1;
                if (sweep_addr_q == LAST_ADDR) begin
                    state_d      = S_IDLE;
                    sweep_addr_d = 11'd0;
                    sweep_x_d    = 6'd0;
                    sweep_y_d    = 6'd0;
                end else begin
                    sweep_addr_d = sweep_addr_q + 11'd1;
                    if (sweep_x_q == LAST_COL) begin
                        sweep_x_d = 6'd0;
                        sweep_y_d = sweep_y_q + 6'd1;
                    end else begin
                        sweep_x_d = sweep_x_q + 6'd1;
                    end
                end
            end
            S_IDLE: begin
                if (start_init_i) begin
                    state_d      = S_INIT;
                    dots_d       = 11'd0;
                    sweep_addr_d = 11'd0;
                    sweep_x_d    = 6'd0;
                    sweep_y_d    = 6'd0;
                end else if (wr_req_i) begin
                    state_d = S_WR_READ;
                    wx_d    = wr_x_i;
                    wy_d    = wr_y_i;
                    wdata_d = wr_data_i;
                end
            end
            S_WR_READ: begin
                state_d = S_WR_COMMIT;
            end
            S_WR_COMMIT: begin
                state_d  = S_IDLE;
                wr_ack_d = 1'b1;
                // Off-grid writes are acknowledged but leave the board untouched
                if (w_wr_in_range) begin
                    w_mem_we   = 1'b1;
                    w_mem_addr = w_wr_addr;
                    w_mem_din  = wdata_q;
                    if (is_edible(old_q) && !is_edible(wdata_q)) begin
                        dots_d = dots_q - 11'd1;
                    end else if (!is_edible(old_q) && is_edible(wdata_q)) begin
                        dots_d = dots_q + 11'd1;
                    end
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_INIT;
            sweep_addr_q <= 11'd0;
            sweep_x_q    <= 6'd0;
            sweep_y_q    <= 6'd0;
            dots_q       <= 11'd0;
            wx_q         <= 6'd0;
            wy_q         <= 6'd0;
            wdata_q      <= 3'd0;
            wr_ack_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sweep_addr_q <= sweep_addr_d;
            sweep_x_q    <= sweep_x_d;
            sweep_y_q    <= sweep_y_d;
            dots_q       <= dots_d;
            wx_q         <= wx_d;
            wy_q         <= wy_d;
            wdata_q      <= wdata_d;
            wr_ack_q     <= wr_ack_d;
        end
    end

    // Array storage carries no reset; the sweep rewrites every cell
    always_ff @(posedge clk_i) begin
        if (w_mem_we) mem_q[w_mem_addr] <= w_mem_din;
        if (state_q == S_WR_READ && w_wr_in_range) old_q <= mem_q[w_wr_addr];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q <= 3'd0;
        end else if (state_q != S_INIT && w_rd_in_range) begin
            rd_data_q <= mem_q[w_rd_addr];
        end else begin
            rd_data_q <= 3'd0;
        end
    end

    assign rd_data_o   = rd_data_q;
    assign wr_ack_o    = wr_ack_q;
    assign init_busy_o = (state_q == S_INIT);
    assign dots_left_o = dots_q;
    assign cleared_o   = (state_q != S_INIT) && (dots_q == 11'd0);

endmodule

`default_nettype wire
